// File: rtl/wb_writer_if.sv
// Write-back stage bundle: MEM-stage handshake, data-memory response and
// register-file write port.
interface wb_writer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic              in_wen;
    logic [REG_W-1:0]  in_wreg;
    logic              in_is_load;
    logic [2:0]        in_load_type;
    logic [1:0]        in_byte_off;
    logic [DATA_W-1:0] in_alu_result;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] wdata;
    logic              RegWrite;
    logic              busy;

    modport master (
        output in_valid, in_wen, in_wreg, in_is_load, in_load_type, in_byte_off,
               in_alu_result, mem_rvalid, mem_rdata,
        input  in_ready, wreg, wdata, RegWrite, busy
    );

    modport slave (
        input  in_valid, in_wen, in_wreg, in_is_load, in_load_type, in_byte_off,
               in_alu_result, mem_rvalid, mem_rdata,
        output in_ready, wreg, wdata, RegWrite, busy
    );
endinterface

// File: rtl/wb_writer.sv
// Write-back stage: ALU results pass through in one cycle; loads wait for the
// memory response, then extract and extend the addressed byte/halfword/word.
module wb_writer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input logic         clk,
    input logic         rst,
    wb_writer_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StWaitMem, StWrite} state_e;

    state_e            state_q, state_d;
    logic [REG_W-1:0]  wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ld_wen_q, ld_wen_d;
    logic [REG_W-1:0]  ld_wreg_q, ld_wreg_d;
    logic [2:0]        ld_type_q, ld_type_d;
    logic [1:0]        ld_off_q, ld_off_d;

    logic              accept;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [DATA_W-1:0] load_data;

    assign bus.in_ready = (state_q != StWaitMem);
    assign bus.busy     = (state_q == StWaitMem);
    // WRITE is only entered with a nonzero destination, so r0 is never written.
    assign bus.RegWrite = (state_q == StWrite);
    assign bus.wreg     = wreg_q;
    assign bus.wdata    = wdata_q;

    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        byte_v = bus.mem_rdata[{ld_off_q, 3'b000} +: 8];
        half_v = bus.mem_rdata[{ld_off_q[1], 4'b0000} +: 16];
        case (ld_type_q)
            3'b000:  load_data = {{(DATA_W-8){byte_v[7]}}, byte_v};
            3'b001:  load_data = {{(DATA_W-8){1'b0}}, byte_v};
            3'b010:  load_data = {{(DATA_W-16){half_v[15]}}, half_v};
            3'b011:  load_data = {{(DATA_W-16){1'b0}}, half_v};
            default: load_data = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wreg_d    = wreg_q;
        wdata_d   = wdata_q;
        ld_wen_d  = ld_wen_q;
        ld_wreg_d = ld_wreg_q;
        ld_type_d = ld_type_q;
        ld_off_d  = ld_off_q;

        case (state_q)
            StWaitMem: begin
                if (bus.mem_rvalid) begin
                    if (ld_wen_q && (ld_wreg_q != '0)) begin
                        wreg_d  = ld_wreg_q;
                        wdata_d = load_data;
                        state_d = StWrite;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                if (accept) begin
                    if (bus.in_is_load) begin
                        ld_wen_d  = bus.in_wen;
                        ld_wreg_d = bus.in_wreg;
                        ld_type_d = bus.in_load_type;
                        ld_off_d  = bus.in_byte_off;
                        state_d   = StWaitMem;
                    end else if (bus.in_wen && (bus.in_wreg != '0)) begin
                        wreg_d  = bus.in_wreg;
                        wdata_d = bus.in_alu_result;
                        state_d = StWrite;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            wreg_q    <= '0;
            wdata_q   <= '0;
            ld_wen_q  <= 1'b0;
            ld_wreg_q <= '0;
            ld_type_q <= '0;
            ld_off_q  <= '0;
        end else begin
            state_q   <= state_d;
            wreg_q    <= wreg_d;
            wdata_q   <= wdata_d;
            ld_wen_q  <= ld_wen_d;
            ld_wreg_q <= ld_wreg_d;
            ld_type_q <= ld_type_d;
            ld_off_q  <= ld_off_d;
        end
    end
endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer: expected register writes are queued as stimulus
// is driven and popped by a write-port monitor.
module tb_wb_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [36:0] sb[$];
    logic [36:0] exp_w;

    always #5 clk = ~clk;

    wb_writer_if #(.DATA_W(32), .REG_W(5)) bus ();

    wb_writer #(.DATA_W(32), .REG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Every register-file write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.RegWrite) begin
            checks++;
            assert (sb.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_write: got wreg=%0d wdata=%h, none expected",
                       bus.wreg, bus.wdata);
            end
            if (sb.size() > 0) begin
                exp_w = sb.pop_front();
                checks++;
                assert ({bus.wreg, bus.wdata} === exp_w) else begin
                    failures++;
                    $error("FAIL write: got wreg=%0d wdata=%h, want wreg=%0d wdata=%h",
                           bus.wreg, bus.wdata, exp_w[36:32], exp_w[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        bus.in_valid      = 1'b0;
        bus.in_wen        = 1'b0;
        bus.in_wreg       = '0;
        bus.in_is_load    = 1'b0;
        bus.in_load_type  = '0;
        bus.in_byte_off   = '0;
        bus.in_alu_result = '0;
    endtask

    task automatic drive_alu(input logic [4:0] r, input logic [31:0] v, input logic wen);
        bus.in_valid      = 1'b1;
        bus.in_is_load    = 1'b0;
        bus.in_wen        = wen;
        bus.in_wreg       = r;
        bus.in_alu_result = v;
        if (wen && r != 0) sb.push_back({r, v});
    endtask

    task automatic drive_load(input logic [4:0] r, input logic [2:0] t, input logic [1:0] off);
        bus.in_valid      = 1'b1;
        bus.in_is_load    = 1'b1;
        bus.in_wen        = 1'b1;
        bus.in_wreg       = r;
        bus.in_load_type  = t;
        bus.in_byte_off   = off;
        bus.in_alu_result = 32'h5555_5555;
    endtask

    // Full load transaction with the response one cycle after acceptance.
    task automatic do_load(input string tag, input logic [2:0] t, input logic [1:0] off,
                           input logic [31:0] rdata, input logic [31:0] exp);
        drive_load(5'd4, t, off);
        tick();
        idle_in();
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        sb.push_back({5'd4, exp});
        tick();
        bus.mem_rvalid = 1'b0;
        chk({tag, "_regwrite"}, 32'(bus.RegWrite), 32'd1);
        tick();
    endtask

    initial begin
        idle_in();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;

        // Reset; a stale response right after reset must be ignored.
        tick();
        tick();
        rst = 1'b0;
        chk("rst_regwrite", 32'(bus.RegWrite), 32'd0);
        chk("rst_wreg", 32'(bus.wreg), 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hBAD0_BAD0;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("stale_rvalid", 32'(bus.RegWrite), 32'd0);

        // Single ALU op.
        drive_alu(5'd5, 32'h1234_5678, 1'b1);
        tick();
        idle_in();
        chk("alu_regwrite", 32'(bus.RegWrite), 32'd1);
        tick();
        chk("alu_done", 32'(bus.RegWrite), 32'd0);

        // Back-to-back ALU ops.
        drive_alu(5'd1, 32'hA, 1'b1);
        tick();
        chk("b2b_ready1", 32'(bus.in_ready), 32'd1);
        drive_alu(5'd2, 32'hB, 1'b1);
        tick();
        chk("b2b_rw2", 32'(bus.RegWrite), 32'd1);
        chk("b2b_ready2", 32'(bus.in_ready), 32'd1);
        drive_alu(5'd3, 32'hC, 1'b1);
        tick();
        idle_in();
        chk("b2b_rw3", 32'(bus.RegWrite), 32'd1);
        tick();
        chk("b2b_done", 32'(bus.RegWrite), 32'd0);

        // ALU op without in_wen writes nothing.
        drive_alu(5'd6, 32'h6666, 1'b0);
        tick();
        idle_in();
        chk("nowen", 32'(bus.RegWrite), 32'd0);

        // Load extraction variants.
        do_load("lb", 3'b000, 2'd3, 32'h80FF_0011, 32'hFFFF_FF80);
        do_load("lbu", 3'b001, 2'd3, 32'h80FF_0011, 32'h0000_0080);
        do_load("lb0", 3'b000, 2'd0, 32'h80FF_0011, 32'h0000_0011);
        do_load("lh", 3'b010, 2'd2, 32'h8001_FFFF, 32'hFFFF_8001);
        do_load("lh3", 3'b010, 2'd3, 32'h8001_7FFF, 32'hFFFF_8001);
        do_load("lhu", 3'b011, 2'd0, 32'h0000_F00F, 32'h0000_F00F);
        do_load("lw", 3'b100, 2'd1, 32'hCAFE_BABE, 32'hCAFE_BABE);
        do_load("lw7", 3'b111, 2'd2, 32'h8765_4321, 32'h8765_4321);

        // Slow response with an ALU op held behind the load.
        drive_load(5'd7, 3'b100, 2'd0);
        tick();
        drive_alu(5'd9, 32'h99, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("slow_busy", 32'(bus.busy), 32'd1);
            chk("slow_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        // Load result is due ahead of the queued ALU write.
        sb.push_front({5'd7, 32'h1122_3344});
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1122_3344;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("slow_ld_rw", 32'(bus.RegWrite), 32'd1);
        chk("slow_ld_reg", 32'(bus.wreg), 32'd7);
        tick();
        idle_in();
        chk("slow_alu_rw", 32'(bus.RegWrite), 32'd1);
        chk("slow_alu_reg", 32'(bus.wreg), 32'd9);
        tick();
        chk("slow_done", 32'(bus.RegWrite), 32'd0);

        // Register 0 is never written.
        drive_alu(5'd0, 32'hDEAD, 1'b1);
        tick();
        idle_in();
        chk("r0_alu", 32'(bus.RegWrite), 32'd0);
        drive_load(5'd0, 3'b100, 2'd0);
        tick();
        idle_in();
        chk("r0_ld_busy1", 32'(bus.busy), 32'd1);
        tick();
        chk("r0_ld_busy2", 32'(bus.busy), 32'd1);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0BAD_F00D;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("r0_ld_rw", 32'(bus.RegWrite), 32'd0);
        chk("r0_ld_idle", 32'(bus.busy), 32'd0);
        chk("r0_ld_ready", 32'(bus.in_ready), 32'd1);

        // Reset while a load is outstanding abandons it.
        drive_load(5'd8, 3'b100, 2'd0);
        tick();
        idle_in();
        chk("rstld_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        chk("rstld_ready", 32'(bus.in_ready), 32'd1);
        chk("rstld_busy0", 32'(bus.busy), 32'd0);
        chk("rstld_wreg", 32'(bus.wreg), 32'd0);
        chk("rstld_wdata", bus.wdata, 32'd0);
        tick();
        bus.mem_rvalid = 1'b0;
        chk("rstld_rw", 32'(bus.RegWrite), 32'd0);
        chk("rstld_wdata2", bus.wdata, 32'd0);
        tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
